cmd_scheduler: RTL and testbench
================================

Name: cmd_scheduler

Overview:
- Sits between the debounced/DAS input command pulses and the game-logic FSM.
- Latches single-cycle command pulses plus the gravity tick into a pending set.
- Resolves conflicts and presents exactly one command at a time over a valid/ready handshake.
- Holds off further commands until game logic reports the previous move/rotate/lock as done.

Parameters:
- TIMEOUT_W, 10, width of BUSY watchdog counter; timeout fires when counter reaches 2^TIMEOUT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  game running; when 0, incoming pulses are not latched
- flush  in  1  pulse; discard all pending commands (piece spawn / game over)
- in_hold, in_drop, in_rot_cw, in_rot_ccw, in_left, in_right, in_down  in  1 each  command pulses
- grav_tick  in  1  gravity step pulse
- cmd_valid  out  1  command offered
- cmd_code  out  3  0 HOLD, 1 DROP, 2 ROT_CW, 3 ROT_CCW, 4 LEFT, 5 RIGHT, 6 DOWN, 7 GRAVITY
- cmd_ready  in  1  game logic accepts offered command
- cmd_done  in  1  pulse; accepted command fully executed
- busy  out  1  high in BUSY state
- err_timeout  out  1  sticky; BUSY watchdog expired
- drop_count  out  8  coalesced/dropped pulses (see Optional Feature)

Behaviour:
- Reset: pending=0, state IDLE, cmd_valid=0, cmd_code=0, busy=0, err_timeout=0, drop_count=0, watchdog=0.
- Pending set: 8 bits indexed by code. A pulse sampled at edge E with enable=1 sets its bit after E.
- Conflict rules, applied to bits not currently offered:
  - in_left sets LEFT and clears RIGHT; in_right sets RIGHT and clears LEFT.
  - in_left and in_right in the same cycle: neither bit set; both existing bits cleared.
  - ROT_CW/ROT_CCW use identical rules.
  - Granting DOWN also clears GRAVITY pending.
- Coalescing: a pulse for a bit that is already pending (and not cleared that cycle) is dropped and counted.
- Arbitration: fixed priority, lowest code wins (HOLD highest, GRAVITY lowest).
- FSM:
  - IDLE: if pending!=0 and flush=0, latch winner into cmd_code and go OFFER. cmd_valid rises the cycle after the pending bit becomes visible, i.e. 2 cycles after the input pulse.
  - OFFER: cmd_valid=1. cmd_code is stable; valid never drops except on flush. On valid&&ready, clear that pending bit and go BUSY with cmd_valid=0 next cycle. A new pulse of the same code in the grant cycle re-sets the bit. On flush without ready, go IDLE and clear all pending.
  - BUSY: busy=1; watchdog increments each cycle. On cmd_done, go IDLE and clear the watchdog. If the watchdog hits all-ones, set err_timeout, go IDLE and clear the watchdog. cmd_done outside BUSY is ignored.
- flush clears all pending bits and beats same-cycle pulses.
- flush in the same cycle as valid&&ready: the transfer completes (go BUSY) and the other pending bits are cleared.
- enable=0 only blocks latching. Already-pending commands continue to be issued.
- Mid-operation rst returns everything to reset values on that edge.

Optional Feature:
- Macro CMD_SCHED_STATS_EN.
- Defined: drop_count increments by the number of pulses dropped per cycle (coalesced or cancelled-by-same-cycle-opposite; cancellations count 2) and saturates at 255.
- Undefined: drop_count is constant 0 and no counter logic is built.

Test Plan:
- Reset, then in_left at cycle 0 with cmd_ready=1 -> cmd_valid=1, cmd_code=4 at cycle 2; busy=1 at cycle 3; cmd_done at cycle 6 -> IDLE, pending=0.
- in_hold, in_drop and grav_tick in the same cycle, ready=1, cmd_done 1 cycle after each grant -> codes issued in order 0, 1, 7.
- in_right pending while LEFT is being offered with ready=0 -> LEFT stays offered and unchanged. A following in_left pulse is coalesced (drop_count=1 with stats enabled) and RIGHT is cleared.
- in_rot_cw and in_rot_ccw in the same cycle -> no offer; drop_count=2 (stats enabled) or 0 (disabled).
- Offer GRAVITY with ready=0, assert flush -> cmd_valid=0 next cycle, state IDLE, no command issued.
- Accept a command, never assert cmd_done -> err_timeout=1 after 1023 BUSY cycles, then IDLE; the next pending command is offered.

Source files
------------

// File: rtl/cmd_scheduler.sv
// cmd_scheduler
// ---------------------------------------------------------------------------
// Sits between the debounced/DAS command pulses and the game-logic FSM.
// Single-cycle command pulses and the gravity tick are latched into an 8-bit
// pending set (bit index == command code). Conflicts are resolved there, the
// lowest pending code wins arbitration, and one command at a time is offered
// over a valid/ready handshake. After a transfer the scheduler waits in BUSY
// until game logic reports cmd_done, guarded by a watchdog.
//
// Command codes: 0 HOLD, 1 DROP, 2 ROT_CW, 3 ROT_CCW, 4 LEFT, 5 RIGHT,
//                6 DOWN, 7 GRAVITY
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   enable           game running; pulses are ignored while low
//   flush            discard every pending command
//   in_*             command pulses (hold, drop, rot_cw, rot_ccw, left,
//                    right, down)
//   grav_tick        gravity step pulse
//   cmd_valid        a command is being offered
//   cmd_code         code of the offered command
//   cmd_ready        game logic accepts the offered command
//   cmd_done         accepted command fully executed
//   busy             waiting for cmd_done
//   err_timeout      sticky, BUSY watchdog expired
//   drop_count       saturating count of coalesced/cancelled pulses
//
// Parameter:
//   TIMEOUT_W        watchdog width; BUSY gives up when the count would
//                    reach 2^TIMEOUT_W-1
//
// Build option:
//   CMD_SCHED_STATS_EN  when defined, drop_count is a live counter;
//                       otherwise it is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module cmd_scheduler #(
    parameter int TIMEOUT_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       flush,
    input  logic       in_hold,
    input  logic       in_drop,
    input  logic       in_rot_cw,
    input  logic       in_rot_ccw,
    input  logic       in_left,
    input  logic       in_right,
    input  logic       in_down,
    input  logic       grav_tick,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    input  logic       cmd_done,
    output logic       busy,
    output logic       err_timeout,
    output logic [7:0] drop_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    // The counter stops one short of all-ones: the edge that would take it
    // to all-ones is the timeout edge.
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [1:0]           state_q,   state_d;
    logic [7:0]           pending_q, pending_d;
    logic [2:0]           code_q,    code_d;
    logic [TIMEOUT_W-1:0] wdog_q,    wdog_d;
    logic                 err_q,     err_d;

    logic [7:0] pulse;
    logic [7:0] eff;
    logic [7:0] opp_clr;
    logic [7:0] grant_clr;
    logic [7:0] kept;
    logic [7:0] code_onehot;
    logic       offered;
    logic       grant;
    logic       lr_both;
    logic       rot_both;
    logic [2:0] winner;

    assign offered     = (state_q == ST_OFFER);
    assign grant       = offered & cmd_ready;
    assign code_onehot = 8'b1 << code_q;

    // Pending-set update. Opposite pulses clear each other's existing bit,
    // but never the bit currently on offer; a same-cycle opposite pair sets
    // nothing. The granted bit (and GRAVITY when DOWN is granted) is cleared
    // before new pulses are OR-ed in, so a same-code pulse re-arms it.
    always_comb begin
        pulse = '0;
        if (enable) begin
            pulse = {grav_tick, in_down, in_right, in_left,
                     in_rot_ccw, in_rot_cw, in_drop, in_hold};
        end
        lr_both  = pulse[4] & pulse[5];
        rot_both = pulse[2] & pulse[3];

        eff = pulse;
        if (lr_both) begin
            eff[5:4] = 2'b00;
        end
        if (rot_both) begin
            eff[3:2] = 2'b00;
        end

        opp_clr    = '0;
        opp_clr[5] = pulse[4];
        opp_clr[4] = pulse[5];
        opp_clr[3] = pulse[2];
        opp_clr[2] = pulse[3];
        if (offered) begin
            opp_clr = opp_clr & ~code_onehot;
        end

        grant_clr = '0;
        if (grant) begin
            grant_clr = code_onehot;
            if (code_q == 3'd6) begin
                grant_clr[7] = 1'b1;
            end
        end

        kept      = pending_q & ~(opp_clr | grant_clr);
        pending_d = flush ? 8'd0 : (kept | eff);
    end

    // Fixed priority: the lowest set index wins.
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        wdog_d  = '0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if ((pending_q != 8'd0) && !flush) begin
                    code_d  = winner;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // A transfer wins over a same-cycle flush.
                if (grant) begin
                    state_d = ST_BUSY;
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cmd_done) begin
                    state_d = ST_IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            code_q    <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
        end
    end

    assign cmd_valid   = offered;
    assign cmd_code    = code_q;
    assign busy        = (state_q == ST_BUSY);
    assign err_timeout = err_q;

`ifdef CMD_SCHED_STATS_EN
    logic [7:0] drop_q, drop_d;
    logic [7:0] coalesced;
    logic [3:0] drop_inc;
    logic [8:0] drop_sum;

    // Drops: pulses whose bit survives this cycle's clears, plus both halves
    // of a cancelled opposite pair. Pulses discarded by flush are not counted.
    always_comb begin
        coalesced = eff & kept;
        drop_inc  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            drop_inc = drop_inc + {3'd0, coalesced[i]};
        end
        if (lr_both) begin
            drop_inc = drop_inc + 4'd2;
        end
        if (rot_both) begin
            drop_inc = drop_inc + 4'd2;
        end
        if (flush) begin
            drop_inc = 4'd0;
        end
        drop_sum = {1'b0, drop_q} + {5'd0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_cmd_scheduler.sv
// tb_cmd_scheduler
// ---------------------------------------------------------------------------
// Directed testbench for cmd_scheduler. Each scenario task drives pulses at
// the falling edge and checks outputs at the falling edge after the relevant
// rising edges, against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cmd_scheduler;

`ifdef CMD_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       flush;
    logic       in_hold, in_drop, in_rot_cw, in_rot_ccw;
    logic       in_left, in_right, in_down, grav_tick;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;
    logic       cmd_done;
    logic       busy;
    logic       err_timeout;
    logic [7:0] drop_count;

    int errors = 0;
    int checks = 0;
    int exp_drop = 0;

    cmd_scheduler #(.TIMEOUT_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .flush       (flush),
        .in_hold     (in_hold),
        .in_drop     (in_drop),
        .in_rot_cw   (in_rot_cw),
        .in_rot_ccw  (in_rot_ccw),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_down     (in_down),
        .grav_tick   (grav_tick),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_ready   (cmd_ready),
        .cmd_done    (cmd_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", cmd_valid); end
        checks++; if (cmd_code !== 3'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 0", cmd_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", err_timeout); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d expected 0", drop_count); end
        rst = 1'b0;
        tick();
    endtask

    // in_left at cycle 0 -> offered at cycle 2, busy at 3, done at 6.
    task automatic test_basic_left();
        cmd_ready = 1'b1;
        in_left = 1'b1;
        tick();
        in_left = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL left_c1_valid: got %0b expected 0", cmd_valid); end
        tick();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL left_c2_valid: got %0b expected 1", cmd_valid); end
        checks++; if (cmd_code !== 3'd4) begin errors++; $display("[TB] FAIL left_c2_code: got %0d expected 4", cmd_code); end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL left_c3_busy: got %0b expected 1", busy); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL left_c3_valid: got %0b expected 0", cmd_valid); end
        tick();
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL left_c6_busy: got %0b expected 1", busy); end
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL left_c7_busy: got %0b expected 0", busy); end
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL left_idle_valid: got %0b expected 0", cmd_valid); end
    endtask

    // HOLD, DROP and GRAVITY together are issued in priority order.
    task automatic test_priority();
        logic [2:0] exp_codes [3];
        logic [2:0] got [8];
        int n;
        exp_codes[0] = 3'd0;
        exp_codes[1] = 3'd1;
        exp_codes[2] = 3'd7;
        n = 0;
        cmd_ready = 1'b1;
        in_hold = 1'b1; in_drop = 1'b1; grav_tick = 1'b1;
        tick();
        in_hold = 1'b0; in_drop = 1'b0; grav_tick = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (cmd_valid === 1'b1 && n < 8) begin
                got[n] = cmd_code;
                n++;
            end
            cmd_done = busy;
            tick();
        end
        cmd_done = 1'b0;
        checks++; if (n !== 3) begin errors++; $display("[TB] FAIL prio_count: got %0d expected 3", n); end
        for (int i = 0; i < 3; i++) begin
            if (i < n) begin
                checks++;
                if (got[i] !== exp_codes[i]) begin errors++; $display("[TB] FAIL prio_code%0d: got %0d expected %0d", i, got[i], exp_codes[i]); end
            end
        end
    endtask

    // RIGHT arrives while LEFT is offered; a later LEFT coalesces and kills RIGHT.
    task automatic test_conflict();
        cmd_ready = 1'b0;
        in_left = 1'b1;
        tick();
        in_left = 1'b0;
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd4) begin errors++; $display("[TB] FAIL conf_offer: got valid=%0b code=%0d expected valid=1 code=4", cmd_valid, cmd_code); end
        in_right = 1'b1;
        tick();
        in_right = 1'b0;
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd4) begin errors++; $display("[TB] FAIL conf_hold_offer: got valid=%0b code=%0d expected valid=1 code=4", cmd_valid, cmd_code); end
        in_left = 1'b1;
        tick();
        in_left = 1'b0;
        if (STATS) exp_drop = exp_drop + 1;
        checks++; if (drop_count !== 8'(exp_drop)) begin errors++; $display("[TB] FAIL conf_drop: got %0d expected %0d", drop_count, exp_drop); end
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd4) begin errors++; $display("[TB] FAIL conf_still_left: got valid=%0b code=%0d expected valid=1 code=4", cmd_valid, cmd_code); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL conf_busy: got %0b expected 1", busy); end
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL conf_right_cleared: got valid=%0b code=%0d expected valid=0", cmd_valid, cmd_code); end
    endtask

    task automatic test_rot_cancel();
        cmd_ready = 1'b1;
        in_rot_cw = 1'b1; in_rot_ccw = 1'b1;
        tick();
        in_rot_cw = 1'b0; in_rot_ccw = 1'b0;
        if (STATS) exp_drop = exp_drop + 2;
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rot_no_offer: got valid=%0b busy=%0b expected 0 0", cmd_valid, busy); end
        checks++; if (drop_count !== 8'(exp_drop)) begin errors++; $display("[TB] FAIL rot_drop: got %0d expected %0d", drop_count, exp_drop); end
    endtask

    task automatic test_enable_off();
        cmd_ready = 1'b1;
        enable = 1'b0;
        in_hold = 1'b1;
        tick();
        in_hold = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL enable_block: got valid=%0b busy=%0b expected 0 0", cmd_valid, busy); end
    endtask

    // DOWN and GRAVITY together: DOWN wins and its grant removes GRAVITY.
    task automatic test_down_gravity();
        cmd_ready = 1'b0;
        in_down = 1'b1; grav_tick = 1'b1;
        tick();
        in_down = 1'b0; grav_tick = 1'b0;
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd6) begin errors++; $display("[TB] FAIL down_offer: got valid=%0b code=%0d expected valid=1 code=6", cmd_valid, cmd_code); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL down_clears_grav: got valid=%0b code=%0d expected valid=0", cmd_valid, cmd_code); end
    endtask

    task automatic test_flush();
        cmd_ready = 1'b0;
        grav_tick = 1'b1;
        tick();
        grav_tick = 1'b0;
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd7) begin errors++; $display("[TB] FAIL flush_offer: got valid=%0b code=%0d expected valid=1 code=7", cmd_valid, cmd_code); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: got valid=%0b busy=%0b expected 0 0", cmd_valid, busy); end
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_cleared: got %0b expected 0", cmd_valid); end
    endtask

    task automatic test_timeout();
        int busy_cycles;
        cmd_ready = 1'b1;
        in_down = 1'b1;
        tick();
        in_down = 1'b0;
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd6) begin errors++; $display("[TB] FAIL to_offer: got valid=%0b code=%0d expected valid=1 code=6", cmd_valid, cmd_code); end
        tick();
        cmd_ready = 1'b0;
        busy_cycles = 0;
        if (busy === 1'b1) busy_cycles = 1;
        in_left = 1'b1;
        tick();
        in_left = 1'b0;
        for (int i = 0; i < 1100 && busy === 1'b1; i++) begin
            busy_cycles++;
            if (busy_cycles == 1000) begin
                checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_err_early: got %0b expected 0", err_timeout); end
            end
            tick();
        end
        checks++; if (busy_cycles !== 1023) begin errors++; $display("[TB] FAIL to_busy_cycles: got %0d expected 1023", busy_cycles); end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got %0b expected 1", err_timeout); end
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd4) begin errors++; $display("[TB] FAIL to_next_offer: got valid=%0b code=%0d expected valid=1 code=4", cmd_valid, cmd_code); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        checks++; if (busy !== 1'b0 || err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky: got busy=%0b err=%0b expected 0 1", busy, err_timeout); end
    endtask

    task automatic test_mid_reset();
        cmd_ready = 1'b1;
        in_hold = 1'b1;
        tick();
        in_hold = 1'b0;
        tick();
        tick();
        cmd_ready = 1'b0;
        in_drop = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %0b expected 1", busy); end
        rst = 1'b1;
        tick();
        in_drop = 1'b0;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || err_timeout !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset: got busy=%0b err=%0b drop=%0d expected 0 0 0", busy, err_timeout, drop_count); end
        tick();
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_pending_cleared: got %0b expected 0", cmd_valid); end
        exp_drop = 0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; flush = 1'b0;
        in_hold = 1'b0; in_drop = 1'b0; in_rot_cw = 1'b0; in_rot_ccw = 1'b0;
        in_left = 1'b0; in_right = 1'b0; in_down = 1'b0; grav_tick = 1'b0;
        cmd_ready = 1'b0; cmd_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_left();
        test_priority();
        test_conflict();
        test_rot_cancel();
        test_enable_off();
        test_down_gravity();
        test_flush();
        test_timeout();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
